wm8978_cfg_seq: RTL and testbench

Power-up configuration sequencer for the WM8978 codec. It walks a fixed 12-entry register table and issues one 16-bit control word per entry to the team's I2C master through a start/done handshake, with timeout, NACK retry and error reporting. Register R4 is built from the capture word length, so codec framing always matches the audio receiver's WL. cfg_done gates enabling of the audio capture / FIR / FFT path.

---
 rtl/wm8978_pkg.sv | 40 ++++
 rtl/wm8978_cfg_seq_if.sv | 10 +
 rtl/wm8978_reg_rom.sv | 32 +++
 rtl/wm8978_cfg_seq.sv | 123 ++++++++++++
 tb/tb_wm8978_cfg_seq.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wm8978_pkg.sv
// Shared types and constants for the WM8978 power-up configuration sequencer.
package wm8978_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    ISSUE,
    WAIT,
    FAIL,
    NEXT,
    GAP,
    DONE,
    ERR
  } state_t;

  localparam int REG_NUM = 12;

  localparam logic [6:0] ADDR_R0  = 7'd0;
  localparam logic [6:0] ADDR_R1  = 7'd1;
  localparam logic [6:0] ADDR_R2  = 7'd2;
  localparam logic [6:0] ADDR_R3  = 7'd3;
  localparam logic [6:0] ADDR_R4  = 7'd4;
  localparam logic [6:0] ADDR_R6  = 7'd6;
  localparam logic [6:0] ADDR_R7  = 7'd7;
  localparam logic [6:0] ADDR_R14 = 7'd14;
  localparam logic [6:0] ADDR_R44 = 7'd44;
  localparam logic [6:0] ADDR_R45 = 7'd45;
  localparam logic [6:0] ADDR_R46 = 7'd46;
  localparam logic [6:0] ADDR_R47 = 7'd47;

  // Audio interface word-length field of R4; unsupported lengths fall back to 32 bit.
  function automatic logic [1:0] wl_code(input logic [5:0] wl);
    case (wl)
      6'd16:   return 2'b00;
      6'd20:   return 2'b01;
      6'd24:   return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/wm8978_cfg_seq_if.sv
// Write-request handshake between the configuration sequencer and the I2C master.
interface wm8978_cfg_seq_if;
  logic        i2c_exec;
  logic [15:0] i2c_data;
  logic        i2c_done;
  logic        i2c_ack;

  modport master (output i2c_exec, output i2c_data, input i2c_done, input i2c_ack);
  modport slave  (input i2c_exec, input i2c_data, output i2c_done, output i2c_ack);
endinterface

// File: rtl/wm8978_reg_rom.sv
// Fixed power-up register table: index -> {reg_addr[6:0], reg_val[8:0]}.
module wm8978_reg_rom
  import wm8978_pkg::*;
#(
  parameter logic [5:0] WL     = 6'd32,
  parameter logic [5:0] VOLUME = 6'd48
) (
  input  logic [3:0]  idx,
  output logic [15:0] word
);

  // Table lookup; indices past the end read as zero.
  always_comb begin
    word = 16'h0000;
    case (idx)
      4'd0:    word = {ADDR_R0,  9'h000};
      4'd1:    word = {ADDR_R1,  9'h01B};
      4'd2:    word = {ADDR_R2,  9'h1B0};
      4'd3:    word = {ADDR_R3,  9'h06F};
      4'd4:    word = {ADDR_R4,  2'b00, wl_code(WL), 2'b10, 3'b000};
      4'd5:    word = {ADDR_R6,  9'h000};
      4'd6:    word = {ADDR_R7,  9'h000};
      4'd7:    word = {ADDR_R14, 9'h108};
      4'd8:    word = {ADDR_R44, 9'h033};
      4'd9:    word = {ADDR_R45, 3'b100, VOLUME};
      4'd10:   word = {ADDR_R46, 3'b100, VOLUME};
      4'd11:   word = {ADDR_R47, 9'h100};
      default: word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/wm8978_cfg_seq.sv
// WM8978 power-up configuration sequencer.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   PWR_WAIT | codec supply settling delay after reset
//   ISSUE    | one-cycle write request for table[reg_idx]
//   WAIT     | waiting for the I2C master's done pulse or timeout
//   FAIL     | NACK or timeout: retry same entry or give up
//   NEXT     | entry accepted, advance the index
//   GAP      | settling delay after the R0 soft reset
//   DONE     | table written, capture path may be enabled
//   ERR      | an entry ran out of retries
module wm8978_cfg_seq
  import wm8978_pkg::*;
#(
  parameter logic [5:0]  WL        = 6'd32,
  parameter logic [5:0]  VOLUME    = 6'd48,
  parameter logic [19:0] PWR_DLY   = 20'd50000,
  parameter logic [15:0] RST_GAP   = 16'd1000,
  parameter logic [19:0] TIMEOUT   = 20'd200000,
  parameter logic [1:0]  MAX_RETRY = 2'd3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reconfig,
  wm8978_cfg_seq_if.master         i2c,
  output logic                     cfg_busy,
  output logic                     cfg_done,
  output logic                     cfg_err,
  output logic [3:0]               reg_idx
);

  state_t      state;
  state_t      state_nxt;
  logic [19:0] pwr_cnt;
  logic [15:0] gap_cnt;
  logic [19:0] to_cnt;
  logic [1:0]  retry_cnt;
  logic        pwr_tc;
  logic        gap_tc;
  logic        to_tc;
  logic        retry_last;
  logic [15:0] rom_word;

  wm8978_reg_rom #(.WL(WL), .VOLUME(VOLUME)) u_rom (
    .idx  (reg_idx),
    .word (rom_word)
  );

  // Terminal counts are compared one bit wider so a zero parameter cannot wrap.
  assign pwr_tc     = ({1'b0, pwr_cnt} + 21'd1) >= {1'b0, PWR_DLY};
  assign gap_tc     = ({1'b0, gap_cnt} + 17'd1) >= {1'b0, RST_GAP};
  assign to_tc      = ({1'b0, to_cnt} + 21'd1) >= {1'b0, TIMEOUT};
  assign retry_last = ({1'b0, retry_cnt} + 3'd1) >= {1'b0, MAX_RETRY};

  // The data word follows reg_idx, which is frozen from ISSUE through WAIT.
  assign i2c.i2c_exec = (state == ISSUE);
  assign i2c.i2c_data = rom_word;
  assign cfg_busy     = (state != DONE) && (state != ERR);
  assign cfg_done     = (state == DONE);
  assign cfg_err      = (state == ERR);

  // Next-state decode; done beats a timeout landing on the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      PWR_WAIT: if (pwr_tc) state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT;
      WAIT: begin
        if (i2c.i2c_done)  state_nxt = i2c.i2c_ack ? FAIL : NEXT;
        else if (to_tc)    state_nxt = FAIL;
      end
      FAIL:     state_nxt = retry_last ? ERR : ISSUE;
      NEXT: begin
        if (reg_idx == 4'(REG_NUM - 1)) state_nxt = DONE;
        else if (reg_idx == 4'd0)       state_nxt = GAP;
        else                            state_nxt = ISSUE;
      end
      GAP:      if (gap_tc) state_nxt = ISSUE;
      DONE,
      ERR:      if (reconfig) state_nxt = ISSUE;
      default:  state_nxt = PWR_WAIT;
    endcase
  end

  // State register plus saturating counters and table index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PWR_WAIT;
      reg_idx   <= 4'd0;
      retry_cnt <= 2'd0;
      pwr_cnt   <= 20'd0;
      gap_cnt   <= 16'd0;
      to_cnt    <= 20'd0;
    end else begin
      state <= state_nxt;
      case (state)
        PWR_WAIT: if (!pwr_tc) pwr_cnt <= pwr_cnt + 20'd1;
        ISSUE:    to_cnt <= 20'd0;
        WAIT:     if (!to_tc) to_cnt <= to_cnt + 20'd1;
        FAIL:     if (retry_cnt != 2'b11) retry_cnt <= retry_cnt + 2'd1;
        NEXT: begin
          retry_cnt <= 2'd0;
          gap_cnt   <= 16'd0;
          if (reg_idx != 4'(REG_NUM - 1) && reg_idx != 4'd0) reg_idx <= reg_idx + 4'd1;
        end
        GAP: begin
          if (gap_tc) reg_idx <= 4'd1;
          else        gap_cnt <= gap_cnt + 16'd1;
        end
        DONE,
        ERR: begin
          if (reconfig) begin
            reg_idx   <= 4'd0;
            retry_cnt <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wm8978_cfg_seq.sv
// Scoreboard bench for the WM8978 configuration sequencer.
module tb_wm8978_cfg_seq;

  localparam int PWR_DLY = 10;
  localparam int RST_GAP = 5;
  localparam int TIMEOUT = 50;
  localparam logic [23:0] VWL = {6'd8, 6'd20, 6'd24, 6'd16};

  typedef struct {
    logic [15:0] word;
    int          resp;   // 0 ack, 1 nack, 2 never answer
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        reconfig;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [3:0]  reg_idx;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          r0;
  exp_t        sbq[$];
  int          exec_t[$];
  int          done_t[$];
  logic [15:0] tbl [12] = '{16'h0000, 16'h021B, 16'h05B0, 16'h066F, 16'h0870, 16'h0C00,
                            16'h0E00, 16'h1D08, 16'h5833, 16'h5B30, 16'h5D30, 16'h5F00};
  logic [15:0] vexp [4] = '{16'h0810, 16'h0850, 16'h0830, 16'h0870};

  logic        vdone;
  logic        vexec [4];
  logic [15:0] vdata [4];
  logic        vbusy [4];
  logic        vdn   [4];
  logic        verr  [4];
  logic [3:0]  vidx  [4];

  wm8978_cfg_seq_if ifc ();

  wm8978_cfg_seq #(
    .PWR_DLY (20'(PWR_DLY)),
    .RST_GAP (16'(RST_GAP)),
    .TIMEOUT (20'(TIMEOUT))
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .reconfig (reconfig),
    .i2c      (ifc),
    .cfg_busy (cfg_busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .reg_idx  (reg_idx)
  );

  for (genvar g = 0; g < 4; g++) begin : g_wl
    wm8978_cfg_seq_if vif ();
    assign vif.i2c_done = vdone;
    assign vif.i2c_ack  = 1'b0;
    assign vexec[g]     = vif.i2c_exec;
    assign vdata[g]     = vif.i2c_data;
    wm8978_cfg_seq #(
      .WL      (VWL[g*6 +: 6]),
      .PWR_DLY (20'd4),
      .RST_GAP (16'd2),
      .TIMEOUT (20'd50)
    ) u_var (
      .clk      (clk),
      .rst      (rst),
      .reconfig (1'b0),
      .i2c      (vif),
      .cfg_busy (vbusy[g]),
      .cfg_done (vdn[g]),
      .cfg_err  (verr[g]),
      .reg_idx  (vidx[g])
    );
  end

  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [15:0] w, input int resp, input int lat);
    exp_t e;
    e.word = w;
    e.resp = resp;
    e.lat  = lat;
    sbq.push_back(e);
  endtask

  task automatic push_table(input int first, input int last, input int lat);
    for (int i = first; i <= last; i++) push(tbl[i], 0, lat);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.i2c_done = 1'b0;
    ifc.i2c_ack  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r0 = cyc;
    exec_t.delete();
    done_t.delete();
  endtask

  task automatic pulse_reconfig();
    reconfig = 1'b1;
    @(negedge clk);
    reconfig = 1'b0;
  endtask

  task automatic wait_exec(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (ifc.i2c_exec === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Acts as the I2C master: pops the expected word per request, answers as planned.
  task automatic run_model();
    exp_t e;
    bit   ok;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_exec(300, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL exec_wait: no i2c_exec within 300 cycles, required word %h", e.word);
        sbq.delete();
        break;
      end
      exec_t.push_back(cyc);
      tests++;
      if (ifc.i2c_data !== e.word) begin
        fails++;
        $display("FAIL exec_data: request #%0d got %h, required %h", exec_t.size() - 1, ifc.i2c_data, e.word);
      end
      @(negedge clk);
      tests++;
      if (ifc.i2c_exec !== 1'b0 || ifc.i2c_data !== e.word) begin
        fails++;
        $display("FAIL exec_hold: exec=%b data=%h one cycle later, required exec=0 data=%h",
                 ifc.i2c_exec, ifc.i2c_data, e.word);
      end
      if (e.resp != 2) begin
        repeat (e.lat - 1) @(negedge clk);
        ifc.i2c_done = 1'b1;
        ifc.i2c_ack  = (e.resp == 1);
        done_t.push_back(cyc);
        @(negedge clk);
        ifc.i2c_done = 1'b0;
        ifc.i2c_ack  = 1'b0;
      end
    end
  endtask

  task automatic expect_quiet(input int n, input string name);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ifc.i2c_exec === 1'b1) cnt++;
    end
    tests++;
    if (cnt != 0) begin
      fails++;
      $display("FAIL %s: %0d exec pulses seen, required 0", name, cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({ifc.i2c_exec, ifc.i2c_data} !== 17'h0) begin
      fails++;
      $display("FAIL reset_bus: exec=%b data=%h, required 0/0000", ifc.i2c_exec, ifc.i2c_data);
    end
    tests++;
    if ({cfg_busy, cfg_done, cfg_err, reg_idx} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      fails++;
      $display("FAIL reset_status: busy/done/err/idx=%b%b%b/%0d, required 100/0",
               cfg_busy, cfg_done, cfg_err, reg_idx);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    push_table(0, 11, 20);
    run_model();
    tests++;
    if (exec_t.size() != 12) begin
      fails++;
      $display("FAIL nom_count: %0d requests, required 12", exec_t.size());
    end
    if (exec_t.size() >= 3 && done_t.size() >= 2) begin
      tests++;
      if (exec_t[0] - r0 < PWR_DLY || exec_t[0] - r0 > PWR_DLY + 1) begin
        fails++;
        $display("FAIL nom_pwr_dly: first request %0d cycles after reset, required %0d..%0d",
                 exec_t[0] - r0, PWR_DLY, PWR_DLY + 1);
      end
      tests++;
      if (exec_t[1] - done_t[0] != RST_GAP + 2) begin
        fails++;
        $display("FAIL nom_rst_gap: done#0 to exec#1 = %0d cycles, required %0d",
                 exec_t[1] - done_t[0], RST_GAP + 2);
      end
      tests++;
      if (exec_t[2] - done_t[1] != 2) begin
        fails++;
        $display("FAIL nom_step: done#1 to exec#2 = %0d cycles, required 2", exec_t[2] - done_t[1]);
      end
    end
    repeat (2) @(negedge clk);
    tests++;
    if ({cfg_busy, cfg_done, cfg_err, reg_idx} !== {1'b0, 1'b1, 1'b0, 4'd11}) begin
      fails++;
      $display("FAIL nom_done: busy/done/err/idx=%b%b%b/%0d, required 010/11",
               cfg_busy, cfg_done, cfg_err, reg_idx);
    end
    expect_quiet(30, "nom_quiet");
  endtask

  task automatic test_wl_variants();
    bit ok;
    do_reset();
    vdone = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (vexec[0] === 1'b1) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL wl_exec_wait: variant request %0d not seen within 100 cycles", i);
        break;
      end
      if (i == 4) begin
        for (int g = 0; g < 4; g++) begin
          tests++;
          if (vdata[g] !== vexp[g]) begin
            fails++;
            $display("FAIL wl_r4: WL=%0d word %h, required %h", VWL[g*6 +: 6], vdata[g], vexp[g]);
          end
          tests++;
          if ({vbusy[g], vdn[g], verr[g], vidx[g]} !== {1'b1, 1'b0, 1'b0, 4'd4}) begin
            fails++;
            $display("FAIL wl_status: variant %0d busy/done/err/idx=%b%b%b/%0d, required 100/4",
                     g, vbusy[g], vdn[g], verr[g], vidx[g]);
          end
        end
      end else begin
        @(negedge clk);
        vdone = 1'b1;
        @(negedge clk);
        vdone = 1'b0;
      end
    end
  endtask

  task automatic test_nack_retry();
    do_reset();
    push_table(0, 2, 20);
    push(tbl[3], 1, 20);
    push(tbl[3], 1, 20);
    push(tbl[3], 0, 20);
    push_table(4, 11, 20);
    run_model();
    tests++;
    if (exec_t.size() != 14) begin
      fails++;
      $display("FAIL retry_count: %0d requests, required 14", exec_t.size());
    end
    repeat (2) @(negedge clk);
    tests++;
    if ({cfg_done, cfg_err} !== 2'b10) begin
      fails++;
      $display("FAIL retry_done: done/err=%b%b, required 10", cfg_done, cfg_err);
    end
  endtask

  task automatic test_nack_error();
    do_reset();
    push_table(0, 4, 20);
    repeat (3) push(tbl[5], 1, 20);
    run_model();
    repeat (2) @(negedge clk);
    tests++;
    if ({cfg_busy, cfg_done, cfg_err, reg_idx} !== {1'b0, 1'b0, 1'b1, 4'd5}) begin
      fails++;
      $display("FAIL nack_err: busy/done/err/idx=%b%b%b/%0d, required 001/5",
               cfg_busy, cfg_done, cfg_err, reg_idx);
    end
    expect_quiet(40, "nack_err_quiet");
    pulse_reconfig();
    tests++;
    if ({ifc.i2c_exec, ifc.i2c_data} !== {1'b1, 16'h0000}) begin
      fails++;
      $display("FAIL reconfig_restart: exec=%b data=%h one cycle after reconfig, required 1/0000",
               ifc.i2c_exec, ifc.i2c_data);
    end
    exec_t.delete();
    push_table(0, 11, 20);
    run_model();
    repeat (2) @(negedge clk);
    tests++;
    if ({cfg_done, cfg_err, exec_t.size() == 12} !== 3'b101) begin
      fails++;
      $display("FAIL reconfig_done: done/err=%b%b requests=%0d, required 10 and 12",
               cfg_done, cfg_err, exec_t.size());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (3) push(tbl[0], 2, 0);
    run_model();
    tests++;
    if (exec_t.size() != 3 || exec_t[1] - exec_t[0] != TIMEOUT + 2 || exec_t[2] - exec_t[1] != TIMEOUT + 2) begin
      fails++;
      $display("FAIL to_spacing: %0d requests, spacing %0d/%0d, required 3 requests spaced %0d",
               exec_t.size(), exec_t.size() > 1 ? exec_t[1] - exec_t[0] : -1,
               exec_t.size() > 2 ? exec_t[2] - exec_t[1] : -1, TIMEOUT + 2);
    end
    expect_quiet(60, "to_quiet");
    tests++;
    if ({cfg_err, reg_idx} !== {1'b1, 4'd0}) begin
      fails++;
      $display("FAIL to_err: err/idx=%b/%0d, required 1/0", cfg_err, reg_idx);
    end
    pulse_reconfig();
    push(tbl[0], 0, TIMEOUT);
    push_table(1, 11, 20);
    run_model();
    repeat (2) @(negedge clk);
    tests++;
    if ({cfg_done, cfg_err} !== 2'b10) begin
      fails++;
      $display("FAIL to_tie_done: done/err=%b%b, required 10", cfg_done, cfg_err);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    push_table(0, 6, 20);
    push(tbl[7], 2, 0);
    run_model();
    pulse_reconfig();
    repeat (3) @(negedge clk);
    tests++;
    if ({cfg_busy, cfg_done, reg_idx} !== {1'b1, 1'b0, 4'd7}) begin
      fails++;
      $display("FAIL busy_reconfig: busy/done/idx=%b%b/%0d, required 10/7", cfg_busy, cfg_done, reg_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({ifc.i2c_exec, ifc.i2c_data, cfg_busy, cfg_done, cfg_err, reg_idx} !==
        {1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0}) begin
      fails++;
      $display("FAIL mid_reset: exec=%b data=%h busy/done/err=%b%b%b idx=%0d, required 0/0000/100/0",
               ifc.i2c_exec, ifc.i2c_data, cfg_busy, cfg_done, cfg_err, reg_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    r0 = cyc;
    exec_t.delete();
    repeat (3) @(negedge clk);
    ifc.i2c_done = 1'b1;
    @(negedge clk);
    ifc.i2c_done = 1'b0;
    push_table(0, 11, 20);
    run_model();
    tests++;
    if (exec_t.size() != 12 || exec_t[0] - r0 < PWR_DLY || exec_t[0] - r0 > PWR_DLY + 1) begin
      fails++;
      $display("FAIL mid_restart: %0d requests, first at %0d cycles, required 12 at %0d..%0d",
               exec_t.size(), exec_t.size() > 0 ? exec_t[0] - r0 : -1, PWR_DLY, PWR_DLY + 1);
    end
    repeat (2) @(negedge clk);
    tests++;
    if ({cfg_busy, cfg_done} !== 2'b01) begin
      fails++;
      $display("FAIL mid_done: busy/done=%b%b, required 01", cfg_busy, cfg_done);
    end
  endtask

  initial begin
    rst          = 1'b1;
    reconfig     = 1'b0;
    vdone        = 1'b0;
    ifc.i2c_done = 1'b0;
    ifc.i2c_ack  = 1'b0;
    test_reset();
    test_nominal();
    test_wl_variants();
    test_nack_retry();
    test_nack_error();
    test_timeout();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
